// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter
// Round-robin arbiter with grant hold for a shared single-port resource.
// A winner owns the resource for a multi-cycle transaction until it signals
// last, drops its request, or reaches MAX_HOLD cycles of ownership. Priority
// then rotates past the released owner. A release and the next grant happen
// on the same edge, so ownership hands over without an idle gap.
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N),
    parameter int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            timeout
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Registered state
    state_t            state_reg,       state_next;
    logic [ID_W-1:0]   owner_reg,       owner_next;
    logic [ID_W-1:0]   ptr_reg,         ptr_next;
    logic [CNT_W-1:0]  hold_cnt_reg,    hold_cnt_next;
    logic [N-1:0]      grant_reg,       grant_next;
    logic              grant_valid_reg, grant_valid_next;
    logic [ID_W-1:0]   grant_id_reg,    grant_id_next;
    logic              timeout_reg,     timeout_next;

    // Release decode for the current owner
    logic              owner_req;
    logic              owner_last;
    logic              at_limit;
    logic              rel_last;
    logic              rel_drop;
    logic              rel_tmo;
    logic              release_now;

    // Round-robin selection
    logic [ID_W-1:0]   sel_ptr;
    logic [N-1:0]      above_ptr;
    logic [N-1:0]      req_hi;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   lo_idx;
    logic              hi_any;
    logic              win_any;
    logic [ID_W-1:0]   win_id;

    // Owner-side release conditions; last only counts while the owner still requests
    always_comb begin
        owner_req   = req[owner_reg];
        owner_last  = last[owner_reg];
        at_limit    = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
        rel_last    = owner_req & owner_last;
        rel_drop    = ~owner_req;
        rel_tmo     = owner_req & ~owner_last & at_limit;
        release_now = (state_reg == ST_OWN) & (rel_last | rel_drop | rel_tmo);
    end

    // On release the outgoing owner becomes the rotation point immediately,
    // so it can only re-win when it is the sole requester.
    assign sel_ptr = (state_reg == ST_OWN) ? owner_reg : ptr_reg;

    // Requesters strictly after the pointer form the high-priority group
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_above
            assign above_ptr[gi] = (ID_W'(gi) > sel_ptr);
        end
    endgenerate

    assign req_hi = req & above_ptr;

    // Lowest-index set bit of each group; wrap-around falls to the full request vector
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                hi_idx = ID_W'(i);
            end
            if (req[i]) begin
                lo_idx = ID_W'(i);
            end
        end
    end

    assign hi_any  = |req_hi;
    assign win_any = |req;
    assign win_id  = hi_any ? hi_idx : lo_idx;

    // Next-state and registered-output computation
    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        ptr_next         = ptr_reg;
        hold_cnt_next    = hold_cnt_reg;
        grant_next       = grant_reg;
        grant_valid_next = grant_valid_reg;
        grant_id_next    = grant_id_reg;
        timeout_next     = 1'b0;

        if (state_reg == ST_OWN && !release_now) begin
            hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end else begin
            if (release_now) begin
                ptr_next     = owner_reg;
                timeout_next = rel_tmo;
            end
            hold_cnt_next = '0;
            if (win_any) begin
                state_next          = ST_OWN;
                owner_next          = win_id;
                grant_next          = '0;
                grant_next[win_id]  = 1'b1;
                grant_valid_next    = 1'b1;
                grant_id_next       = win_id;
            end else begin
                state_next       = ST_IDLE;
                owner_next       = '0;
                grant_next       = '0;
                grant_valid_next = 1'b0;
                grant_id_next    = '0;
            end
        end
    end

    // State and output registers; reset overrides any ownership in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= '0;
            ptr_reg         <= ID_W'(N - 1);
            hold_cnt_reg    <= '0;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_id_reg    <= '0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            ptr_reg         <= ptr_next;
            hold_cnt_reg    <= hold_cnt_next;
            grant_reg       <= grant_next;
            grant_valid_reg <= grant_valid_next;
            grant_id_reg    <= grant_id_next;
            timeout_reg     <= timeout_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_id    = grant_id_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Testbench for rr_hold_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against an ownership-level reference model.
module tb_rr_hold_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int ID_W     = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    last;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            timeout;

    always #5 clk = ~clk;

    rr_hold_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .last        (last),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cyc           = 0;

    // Reference model: who owns the resource, how many cycles it has held it,
    // where the rotation starts, and whether the last handover was forced.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_held  = 0;
    bit m_to    = 1'b0;
    int prev_owner = -2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // First requester after p in circular order, p itself last; -1 if none
    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (p + off) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs presented this cycle
    task automatic model_step();
        if (rst) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_held  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to    = 1'b0;
            m_owner = pick(m_ptr, req);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else begin
            bit rel;
            bit forced;
            rel    = 1'b0;
            forced = 1'b0;
            if (!req[m_owner])                  rel = 1'b1;
            else if (last[m_owner])             rel = 1'b1;
            else if (m_held == MAX_HOLD) begin  rel = 1'b1; forced = 1'b1; end
            m_to = forced;
            if (rel) begin
                m_ptr   = m_owner;
                m_owner = pick(m_ptr, req);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_grant;
        exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        check_eq("grant",       32'(grant),       exp_grant);
        check_eq("grant_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("grant_id",    32'(grant_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_eq("timeout",     32'(timeout),     32'(m_to));
        if (m_owner != prev_owner || m_to) begin
            $display("cycle %0d: grant=%b id=%0d valid=%0b timeout=%0b (model owner %0d)",
                     cyc, grant, grant_id, grant_valid, timeout, m_owner);
        end
        prev_owner = m_owner;
    endtask

    // One clock: present inputs, clock the DUT and model, then compare after the edge
    task automatic cycle(input logic r, input logic [N-1:0] q, input logic [N-1:0] l);
        rst  = r;
        req  = q;
        last = l;
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare_all();
    endtask

    function automatic logic [N-1:0] owner_bit();
        return (m_owner >= 0) ? N'(1 << m_owner) : '0;
    endfunction

    initial begin
        rst  = 1'b1;
        req  = '0;
        last = '0;

        // Reset state
        cycle(1'b1, '0, '0);
        cycle(1'b1, '0, '0);
        cycle(1'b0, '0, '0);

        // Two requesters, last on each owner's third cycle
        for (int i = 0; i < 14; i++)
            cycle(1'b0, 4'b0101, (m_held == 3) ? owner_bit() : '0);

        // Everyone requesting, never last: forced handovers every MAX_HOLD cycles
        for (int i = 0; i < 5 * MAX_HOLD; i++)
            cycle(1'b0, 4'b1111, '0);

        // Sole requester re-wins every cycle
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 4'b0100, 4'b1111);

        // Owner 1 drops after two cycles while requester 3 waits
        cycle(1'b1, '0, '0);
        cycle(1'b0, 4'b0010, '0);
        cycle(1'b0, 4'b1010, '0);
        cycle(1'b0, 4'b1000, '0);
        cycle(1'b0, 4'b1010, '0);
        cycle(1'b0, 4'b1010, '0);

        // Reset in the middle of requester 3's ownership
        cycle(1'b1, '0, '0);
        cycle(1'b0, 4'b1000, '0);
        cycle(1'b0, 4'b1000, '0);
        cycle(1'b1, 4'b1000, '0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'b1111, '0);

        // Last exactly at the hold limit, with last also raised on a non-owner
        cycle(1'b1, '0, '0);
        for (int i = 0; i < 2 * MAX_HOLD + 2; i++)
            cycle(1'b0, 4'b0011, (m_held == MAX_HOLD) ? 4'b1111 : (~owner_bit() & 4'b1100));

        // Randomized traffic with varying request, drop and last densities
        for (int ph = 0; ph < 6; ph++) begin
            int req_pct;
            int drop_pct;
            int last_pct;
            req_pct  = 20 + 15 * ph;
            drop_pct = (ph % 3) * 4;
            last_pct = (ph % 2 == 0) ? 5 : 30;
            for (int i = 0; i < 300; i++) begin
                logic [N-1:0] q;
                logic [N-1:0] l;
                for (int j = 0; j < N; j++) begin
                    if (j == m_owner) q[j] = ($urandom_range(99) >= drop_pct);
                    else              q[j] = ($urandom_range(99) < req_pct);
                    l[j] = ($urandom_range(99) < last_pct);
                end
                cycle(($urandom_range(199) == 0), q, l);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Safety net in case the clock or stimulus stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
Round-robin arbiter with grant hold for a shared single-port resource (bus/memory port) among N requesters. Unlike a one-cycle-per-grant FSM, a winner keeps the grant for a multi-cycle transaction until it signals last, drops its request, or hits a hold-limit timeout. Priority then rotates past the released owner. Sits between requester FSMs and the shared resource's mux select.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 8, maximum consecutive grant cycles per ownership (2..256)
ID_W, $clog2(N), width of grant_id
CNT_W, $clog2(MAX_HOLD), width of internal hold counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset: one clock; synchronous, active-high
req  input  N  request per requester; held high while it wants or owns the resource
last  input  N  requester's final transfer cycle; meaningful only when granted
grant  output  N  one-hot grant, registered; all zero when idle
grant_valid  output  1  OR of grant, registered
grant_id  output  ID_W  index of granted requester; 0 when idle
timeout  output  1  one-cycle pulse: current ownership forcibly ended by MAX_HOLD

Behaviour:
- Reset (rst=1 at edge): grant=0, grant_valid=0, grant_id=0, timeout=0, state=IDLE, hold_cnt=0, pointer=N-1 (requester 0 has top priority first). Reset wins over all other activity, including mid-grant.
- States: IDLE (no owner), OWN (one owner k).
- Selection function: from pointer p, first i in order p+1, p+2, ..., p+N (mod N) with req[i]=1. The previous owner p is therefore lowest priority and wins only if sole requester.
- IDLE: if any req, next edge -> OWN, grant[winner]=1, hold_cnt=0. Latency: req high in cycle t -> grant in cycle t+1. No req -> stay IDLE, outputs zero.
- OWN with owner k, release condition evaluated each cycle:
  a) req[k]=1 and last[k]=1 (normal end; this cycle is the final granted cycle);
  b) req[k]=0 (drop; resource unused this cycle);
  c) hold_cnt==MAX_HOLD-1 with neither a) nor b) (timeout).
- No release: keep grant, hold_cnt+1.
- On release: pointer<=k; select among req this same cycle using the new pointer k. If any winner -> OWN with new owner next edge, hold_cnt=0 (back-to-back, no idle gap). Else -> IDLE.
- timeout registered: high in the cycle after condition c), i.e. the first cycle of the next ownership/idle; high for exactly one cycle. Not asserted if a) or b) coincides with the limit.
- last[j] for j!=owner and last with req low are ignored.
- grant always one-hot or zero; grant_id/grant_valid consistent with grant every cycle.
- Ownership lasts at most MAX_HOLD cycles; with all N requesting continuously, each gets a grant within (N-1)*MAX_HOLD+1 cycles of request.

Test Plan:
- Reset then req=4'b0101 held, last pulsed on each owner's 3rd cycle -> grant 0001 x3, 0100 x3, 0001 x3 ...; grant_id 0,2,0; no idle gaps; timeout=0.
- req=4'b1111, last never asserted, MAX_HOLD=8 -> each grant lasts 8 cycles in order 0,1,2,3,0; timeout pulses 1 cycle at each handover.
- Sole requester 2 with req=0100, last every cycle -> grant stays 0100 continuously, grant_id=2, re-won each cycle.
- Owner 1 drops req after 2 cycles while req[3]=1 -> grant 0010 for 2 cycles, then 1000 next cycle; owner 1 becomes lowest priority.
- rst=1 asserted mid-ownership of requester 3 -> next edge all outputs 0; after release with req=1111, first grant goes to requester 0.
- last asserted on exactly the 8th cycle (hold limit) -> normal release, timeout stays 0; last on non-owner line ignored.
